pad_reader: RTL

PAD_READER -- requirements
Module: pad_reader

---
 rtl/pad_reader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pad_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// pad_reader: polls a serial game pad, publishes held levels and press pulses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module pad_reader #(
   parameter int HALF_PERIOD   = 6,
   parameter int POLL_INTERVAL = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pad_data,
   output logic       pad_latch,
   output logic       pad_clk,
   output logic [7:0] buttons_held,
   output logic       btn_A,
   output logic       btn_B,
   output logic       btn_start,
   output logic       btn_up,
   output logic       btn_down,
   output logic       btn_left,
   output logic       btn_right,
   output logic       poll_done
);

   localparam int IW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int PW = $clog2(2 * HALF_PERIOD);
   localparam logic [IW-1:0] c_IDLE_LAST  = IW'(POLL_INTERVAL - 1);
   localparam logic [PW-1:0] c_LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
   localparam logic [PW-1:0] c_HALF_LAST  = PW'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [IW-1:0]   r_idle_cnt;
   logic [PW-1:0]   r_ph_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic [1:0]      r_sync;
   logic [7:0]      r_held;
   logic [6:0]      r_pulse;
   logic            r_done;
   logic [7:0]      w_rise;
   logic [6:0]      w_pulse;
   logic            w_idle_end;
   logic            w_latch_end;
   logic            w_half_end;

   assign w_idle_end  = (r_idle_cnt == c_IDLE_LAST);
   assign w_latch_end = (r_ph_cnt == c_LATCH_LAST);
   assign w_half_end  = (r_ph_cnt == c_HALF_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      pad_latch = 1'b0;
      pad_clk   = 1'b1;
      case (r_state)
         IDLE:     if (w_idle_end) w_next = LATCH;
         LATCH: begin
            pad_latch = 1'b1;
            if (w_latch_end) w_next = SHIFT_LO;
         end
         SHIFT_LO: begin
            pad_clk = 1'b0;
            if (w_half_end) w_next = SHIFT_HI;
         end
         SHIFT_HI: if (w_half_end) w_next = (r_idx == 3'd7) ? DONE : SHIFT_LO;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Exclusivity applies only among buttons newly pressed in this poll.
   always_comb begin
      w_rise     = r_shift & ~r_held;
      w_pulse    = '0;
      w_pulse[0] = w_rise[0];
      w_pulse[1] = w_rise[1] & ~w_rise[0];
      w_pulse[2] = w_rise[3];
      w_pulse[3] = w_rise[4];
      w_pulse[4] = w_rise[5] & ~w_rise[4];
      w_pulse[5] = w_rise[6] & ~|w_rise[5:4];
      w_pulse[6] = w_rise[7] & ~|w_rise[6:4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
         r_ph_cnt   <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_sync     <= 2'b11;
         r_held     <= '0;
         r_pulse    <= '0;
         r_done     <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], pad_data};

         if (r_state == IDLE && !w_idle_end) r_idle_cnt <= r_idle_cnt + IW'(1);
         else                                r_idle_cnt <= '0;

         if (w_next != r_state || r_state == IDLE || r_state == DONE) r_ph_cnt <= '0;
         else                                                           r_ph_cnt <= r_ph_cnt + PW'(1);

         if (r_state == LATCH)                                      r_idx <= '0;
         else if (r_state == SHIFT_HI && w_half_end && r_idx != 3'd7) r_idx <= r_idx + 3'd1;

         // Pad data is active-low; store pressed as 1.
         if (r_state == SHIFT_LO && w_half_end) r_shift[r_idx] <= ~r_sync[1];

         if (r_state == DONE) begin
            r_held  <= r_shift;
            r_pulse <= w_pulse;
            r_done  <= 1'b1;
         end else begin
            r_pulse <= '0;
            r_done  <= 1'b0;
         end
      end
   end

   assign buttons_held = r_held;
   assign poll_done    = r_done;
   assign btn_A        = r_pulse[0];
   assign btn_B        = r_pulse[1];
   assign btn_start    = r_pulse[2];
   assign btn_up       = r_pulse[3];
   assign btn_down     = r_pulse[4];
   assign btn_left     = r_pulse[5];
   assign btn_right    = r_pulse[6];

endmodule
`default_nettype wire
